// File: rtl/mux16_scan_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan sequencer.
// Imported by the encoder and the top level.
package mux16_scan_pkg;

  localparam int CH_W       = 4;
  localparam int N_CH       = 16;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mux16_scan_seq_prio_enc16.sv
// Lowest-set-bit encoder over 16 inputs; purely combinational.
// o_any is low when no bit is set, in which case o_idx is 0.
module prio_enc16
  import mux16_scan_pkg::*;
(
  input  logic [N_CH-1:0] i_vec,
  output logic [CH_W-1:0] o_idx,
  output logic            o_any
);

  // Walk downward so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = CH_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_scan_seq.sv
// Walks the enabled channels of a 16:1 mux, waits SETTLE cycles per select
// change, samples each bit and publishes the assembled 16-bit word with a done pulse.
module mux16_scan_seq
  import mux16_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] mask,
  input  logic            mux_out,
  output logic [CH_W-1:0] mux_sel,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] word,
  output logic            valid
);

  localparam int unsigned SETTLE_LIM = (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE_LIM);
  localparam bit          SETTLE_ZERO = (SETTLE_LIM == 0);
  localparam state_t      ST_AFTER_SEL = SETTLE_ZERO ? ST_SAMPLE : ST_SETTLE;

  state_t          r_state, w_state_n;
  logic [CH_W-1:0] r_mux_sel, w_mux_sel_n;
  logic [3:0]      r_cnt, w_cnt_n;
  logic [N_CH-1:0] r_mask_q, w_mask_q_n;
  logic [N_CH-1:0] r_shadow, w_shadow_n;
  logic [N_CH-1:0] r_word, w_word_n;
  logic            r_valid, w_valid_n;

  logic [CH_W-1:0] w_first_idx, w_next_idx;
  logic            w_first_any, w_next_any;
  logic [N_CH:0]   w_above_wide;
  logic [N_CH-1:0] w_above;
  logic [N_CH-1:0] w_merged;

  // Channels strictly above the current select; widened so sel=15 shifts cleanly to zero.
  assign w_above_wide = {1'b0, r_mask_q} & ~((17'd2 << r_mux_sel) - 17'd1);
  assign w_above      = w_above_wide[N_CH-1:0];
  assign w_merged     = r_shadow | (N_CH'(mux_out) << r_mux_sel);

  prio_enc16 u_first (
    .i_vec (mask),
    .o_idx (w_first_idx),
    .o_any (w_first_any)
  );

  prio_enc16 u_next (
    .i_vec (w_above),
    .o_idx (w_next_idx),
    .o_any (w_next_any)
  );

  always_comb begin
    w_state_n   = r_state;
    w_mux_sel_n = r_mux_sel;
    w_cnt_n     = r_cnt;
    w_mask_q_n  = r_mask_q;
    w_shadow_n  = r_shadow;
    w_word_n    = r_word;
    w_valid_n   = r_valid;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mask_q_n = mask;
          w_shadow_n = '0;
          if (!w_first_any) begin
            w_word_n  = '0;
            w_valid_n = 1'b1;
            w_state_n = ST_DONE;
          end else begin
            w_mux_sel_n = w_first_idx;
            w_cnt_n     = SETTLE_CNT;
            w_state_n   = ST_AFTER_SEL;
          end
        end
      end
      ST_SETTLE: begin
        w_cnt_n = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_shadow_n = w_merged;
        if (w_next_any) begin
          w_mux_sel_n = w_next_idx;
          w_cnt_n     = SETTLE_CNT;
          w_state_n   = ST_AFTER_SEL;
        end else begin
          w_word_n  = w_merged;
          w_valid_n = 1'b1;
          w_state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Abort discards any progress this cycle, including a start being accepted.
    if (abort) begin
      w_state_n   = ST_IDLE;
      w_mux_sel_n = r_mux_sel;
      w_cnt_n     = r_cnt;
      w_mask_q_n  = r_mask_q;
      w_shadow_n  = r_shadow;
      w_word_n    = r_word;
      w_valid_n   = r_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_sel <= '0;
      r_cnt     <= '0;
      r_mask_q  <= '0;
      r_shadow  <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_mux_sel <= w_mux_sel_n;
      r_cnt     <= w_cnt_n;
      r_mask_q  <= w_mask_q_n;
      r_shadow  <= w_shadow_n;
      r_word    <= w_word_n;
      r_valid   <= w_valid_n;
    end
  end

  assign mux_sel = r_mux_sel;
  assign busy    = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done    = (r_state == ST_DONE);
  assign word    = r_word;
  assign valid   = r_valid;

endmodule

// File: tb/tb_mux16_scan_seq.sv
// Directed bench: three sequencer instances (SETTLE 1, 0, 3) each scanning a shared input bus
// through its own behavioural 16:1 mux.
module tb_mux16_scan_seq;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic [15:0] mask;
  logic [15:0] in_bus;

  logic        start_s1, start_s0, start_s3;
  logic        mux_out_s1, mux_out_s0, mux_out_s3;
  logic [3:0]  sel_s1, sel_s0, sel_s3;
  logic        busy_s1, busy_s0, busy_s3;
  logic        done_s1, done_s0, done_s3;
  logic [15:0] word_s1, word_s0, word_s3;
  logic        valid_s1, valid_s0, valid_s3;

  int checks;
  int errors;

  assign mux_out_s1 = in_bus[sel_s1];
  assign mux_out_s0 = in_bus[sel_s0];
  assign mux_out_s3 = in_bus[sel_s3];

  mux16_scan_seq #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1), .abort(abort), .mask(mask),
    .mux_out(mux_out_s1), .mux_sel(sel_s1), .busy(busy_s1), .done(done_s1),
    .word(word_s1), .valid(valid_s1)
  );

  mux16_scan_seq #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s0), .abort(abort), .mask(mask),
    .mux_out(mux_out_s0), .mux_sel(sel_s0), .busy(busy_s0), .done(done_s0),
    .word(word_s0), .valid(valid_s0)
  );

  mux16_scan_seq #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s3), .abort(abort), .mask(mask),
    .mux_out(mux_out_s3), .mux_sel(sel_s3), .busy(busy_s3), .done(done_s3),
    .word(word_s3), .valid(valid_s3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({sel_s1, word_s1, valid_s1, done_s1, busy_s1} !== 23'd0) begin
        errors++;
        $display("FAIL reset_idle_s1 cyc %0d: got sel=%h word=%h valid=%b done=%b busy=%b, expected all 0",
                 k, sel_s1, word_s1, valid_s1, done_s1, busy_s1);
      end
      checks++;
      if ({sel_s0, word_s0, valid_s0, done_s0, busy_s0, sel_s3, word_s3, valid_s3, done_s3, busy_s3} !== 46'd0) begin
        errors++;
        $display("FAIL reset_idle_s0_s3 cyc %0d: got s0 sel=%h word=%h valid=%b, s3 sel=%h word=%h valid=%b, expected 0",
                 k, sel_s0, word_s0, valid_s0, sel_s3, word_s3, valid_s3);
      end
    end
  endtask

  task automatic test_full_scan();
    mask     = 16'hFFFF;
    in_bus   = 16'hA5C3;
    start_s1 = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      if (k == 0) start_s1 = 1'b0;
      if (k <= 31) begin
        checks++;
        if (sel_s1 !== 4'(k / 2)) begin
          errors++;
          $display("FAIL full_sel cyc %0d: got %0d expected %0d", k, sel_s1, k / 2);
        end
        checks++;
        if ({busy_s1, done_s1} !== 2'b10) begin
          errors++;
          $display("FAIL full_busy cyc %0d: got busy=%b done=%b expected busy=1 done=0", k, busy_s1, done_s1);
        end
      end else if (k == 32) begin
        checks++;
        if ({busy_s1, done_s1, valid_s1} !== 3'b011) begin
          errors++;
          $display("FAIL full_done: got busy=%b done=%b valid=%b expected 0 1 1", busy_s1, done_s1, valid_s1);
        end
        checks++;
        if (word_s1 !== 16'hA5C3) begin
          errors++;
          $display("FAIL full_word: got %h expected a5c3", word_s1);
        end
      end else begin
        checks++;
        if ({busy_s1, done_s1, sel_s1} !== {2'b00, 4'd15}) begin
          errors++;
          $display("FAIL full_after: got busy=%b done=%b sel=%0d expected 0 0 15", busy_s1, done_s1, sel_s1);
        end
      end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_sel [0:1];
    exp_sel[0] = 4'd0;
    exp_sel[1] = 4'd15;
    mask     = 16'h8001;
    in_bus   = 16'hFFFF;
    start_s0 = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) start_s0 = 1'b0;
      if (k <= 1) begin
        checks++;
        if ({sel_s0, busy_s0, done_s0} !== {exp_sel[k], 2'b10}) begin
          errors++;
          $display("FAIL sparse_sel cyc %0d: got sel=%0d busy=%b done=%b expected sel=%0d busy=1 done=0",
                   k, sel_s0, busy_s0, done_s0, exp_sel[k]);
        end
      end else if (k == 2) begin
        checks++;
        if ({done_s0, busy_s0, valid_s0, word_s0} !== {3'b101, 16'h8001}) begin
          errors++;
          $display("FAIL sparse_done: got done=%b busy=%b valid=%b word=%h expected 1 0 1 8001",
                   done_s0, busy_s0, valid_s0, word_s0);
        end
      end else begin
        checks++;
        if (done_s0 !== 1'b0) begin
          errors++;
          $display("FAIL sparse_pulse: got done=%b expected 0", done_s0);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    int n_done;
    mask     = 16'h0000;
    start_s1 = 1'b1;
    @(negedge clk);
    start_s1 = 1'b0;
    checks++;
    if ({done_s1, busy_s1, word_s1} !== {2'b10, 16'h0000}) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b word=%h expected 1 0 0000", done_s1, busy_s1, word_s1);
    end
    @(negedge clk);
    checks++;
    if (done_s1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: got done=%b expected 0", done_s1);
    end
    // Two-channel scan with start re-pulsed while busy and while in DONE.
    mask     = 16'h0003;
    in_bus   = 16'h0002;
    start_s1 = 1'b1;
    n_done   = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      start_s1 = (k == 1) || (k == 2) || (k == 4);
      if (done_s1) n_done++;
      if (k == 4) begin
        checks++;
        if ({done_s1, word_s1} !== {1'b1, 16'h0002}) begin
          errors++;
          $display("FAIL ignore_done: got done=%b word=%h expected 1 0002", done_s1, word_s1);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy_s1 !== 1'b0) begin
          errors++;
          $display("FAIL ignore_in_done: got busy=%b expected 0", busy_s1);
        end
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_count: got %0d done pulses expected 1", n_done);
    end
  endtask

  task automatic test_abort();
    // Baseline scan so there is a previous word to preserve.
    mask     = 16'h0011;
    in_bus   = 16'h0010;
    start_s3 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start_s3 = 1'b0;
      if (k == 3) begin
        checks++;
        if ({sel_s3, busy_s3} !== {4'd0, 1'b1}) begin
          errors++;
          $display("FAIL s3_hold: got sel=%0d busy=%b expected 0 1", sel_s3, busy_s3);
        end
      end
      if (k == 4) begin
        checks++;
        if (sel_s3 !== 4'd4) begin
          errors++;
          $display("FAIL s3_step: got sel=%0d expected 4", sel_s3);
        end
      end
    end
    checks++;
    if ({done_s3, word_s3, valid_s3} !== {1'b1, 16'h0010, 1'b1}) begin
      errors++;
      $display("FAIL s3_done: got done=%b word=%h valid=%b expected 1 0010 1", done_s3, word_s3, valid_s3);
    end
    @(negedge clk);
    // Abort after five channels have been sampled.
    mask     = 16'hFFFF;
    in_bus   = 16'h1234;
    start_s3 = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      if (k == 0)  start_s3 = 1'b0;
      if (k == 20) abort = 1'b1;
      if (k == 21) abort = 1'b0;
      if (k == 20) begin
        checks++;
        if ({sel_s3, busy_s3} !== {4'd5, 1'b1}) begin
          errors++;
          $display("FAIL abort_pre: got sel=%0d busy=%b expected 5 1", sel_s3, busy_s3);
        end
      end
      if (k >= 21) begin
        checks++;
        if ({busy_s3, done_s3, sel_s3, word_s3, valid_s3} !== {2'b00, 4'd5, 16'h0010, 1'b1}) begin
          errors++;
          $display("FAIL abort_idle cyc %0d: got busy=%b done=%b sel=%0d word=%h valid=%b expected 0 0 5 0010 1",
                   k, busy_s3, done_s3, sel_s3, word_s3, valid_s3);
        end
      end
    end
    // Restart after abort completes normally.
    mask     = 16'h0100;
    in_bus   = 16'h0100;
    start_s3 = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start_s3 = 1'b0;
        checks++;
        if (sel_s3 !== 4'd8) begin
          errors++;
          $display("FAIL restart_sel: got %0d expected 8", sel_s3);
        end
      end
    end
    checks++;
    if ({done_s3, word_s3} !== {1'b1, 16'h0100}) begin
      errors++;
      $display("FAIL restart_done: got done=%b word=%h expected 1 0100", done_s3, word_s3);
    end
  endtask

  task automatic test_async_reset();
    int n_done;
    @(negedge clk);
    mask     = 16'hFFFF;
    in_bus   = 16'hFFFF;
    start_s3 = 1'b1;
    @(negedge clk);
    start_s3 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_s3, sel_s3} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b sel=%0d expected 1 0", busy_s3, sel_s3);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_s3, done_s3, sel_s3, word_s3, valid_s3} !== 23'd0) begin
      errors++;
      $display("FAIL areset_clear: got busy=%b done=%b sel=%0d word=%h valid=%b expected all 0",
               busy_s3, done_s3, sel_s3, word_s3, valid_s3);
    end
    checks++;
    if ({word_s1, valid_s1, word_s0, valid_s0} !== 34'd0) begin
      errors++;
      $display("FAIL areset_others: got s1 word=%h valid=%b s0 word=%h valid=%b expected 0",
               word_s1, valid_s1, word_s0, valid_s0);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_s3 || busy_s3) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL areset_quiet: got %0d active cycles expected 0", n_done);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    abort    = 1'b0;
    mask     = 16'h0000;
    in_bus   = 16'h0000;
    start_s1 = 1'b0;
    start_s0 = 1'b0;
    start_s3 = 1'b0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_mask_zero();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_scan_seq.md
# mux16_scan_seq

Sequencer that sits directly upstream of the 16-to-1 bit multiplexer. It drives the 4-bit select, waits a programmable settle time, and samples the mux's 1-bit output. It walks every channel enabled in a 16-bit mask in ascending index order and assembles the sampled bits into one 16-bit word. A start/busy/done handshake lets a controller request one full scan of the input bus through the mux.

## Interface
- SETTLE, default 1: wait cycles after each select change before the sample edge; legal range 0..15.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; accepted only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- mask  in  16  channel enable; sampled on the start-accept edge only.
- mux_out  in  1  output of the downstream 16:1 mux.
- mux_sel  out  4  select driven to the mux.
- busy  out  1  high while in SETTLE or SAMPLE.
- done  out  1  one-cycle completion pulse.
- word  out  16  last completed scan result.
- valid  out  1  sticky; set on the first completion and cleared only by reset.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- Reset values: state=IDLE, mux_sel=0, busy=0, done=0, word=0, valid=0, mask_q=0, shadow=0, cnt=0.
- IDLE with start=1:
  - mask_q<=mask; shadow<=0.
  - If mask==0, go to DONE.
  - Otherwise mux_sel<=lowest set index of mask and cnt<=SETTLE. Go to SETTLE if SETTLE>0, else go to SAMPLE.
- SETTLE: cnt<=cnt-1. When cnt==1, go to SAMPLE.
- SAMPLE (one cycle):
  - shadow[mux_sel]<=mux_out.
  - next = lowest set bit of mask_q with index > mux_sel.
  - If next exists: mux_sel<=next, cnt<=SETTLE, and go to SETTLE (or stay in SAMPLE if SETTLE==0).
  - If next does not exist: word<=shadow with the new bit merged, valid<=1, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. start is ignored in DONE.
- Masked channels are never selected. Their word bits are 0.
- start while busy or in DONE is ignored; there is no queueing.
- abort=1 in any state: next state is IDLE. done, word and valid are not updated, and mux_sel holds its value. abort in IDLE has no effect.
- mux_sel changes only on the start-accept edge and on SAMPLE edges. mux_sel holds its value in IDLE.
- Changes to mask during a scan have no effect, because mask_q is used.

## Timing
- Per enabled channel: SETTLE+1 cycles, i.e. SETTLE cycles in SETTLE plus 1 in SAMPLE.
- N enabled channels, start accepted at edge E0:
  - The last sample occurs at edge E0+N*(SETTLE+1).
  - done is high during the following cycle.
  - word and valid change at that same last-sample edge.
- mask==0: done is high in the cycle after E0, and word becomes 0.
- mux_out is sampled exactly SETTLE+1 edges after the edge that set mux_sel. The mux is combinational, so mux_out reflects the current mux_sel.
- busy rises the cycle after E0 and falls when DONE is entered. busy=0 during DONE.
- Reset asserted mid-scan: all outputs immediately take their reset values, with no done pulse. After release, the block idles until start.

## Structure
- Package mux16_scan_pkg holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - CH_W=4 and N_CH=16;
  - the SETTLE range limit.
- Sub-module prio_enc16: combinational lowest-set-bit encoder. Inputs are a 16-bit vector; outputs are idx[3:0] and any. It is reused for both the first-channel and the next-channel lookup; the next-channel lookup feeds it mask_q & ~((2<<mux_sel)-1), widened to 17 bits before masking.
- The top level holds the FSM, cnt, mask_q and shadow.

## Test plan
- Reset then idle: after rst_n release, mux_sel=0, word=0, valid=0 and done=0 for 20 cycles with start=0.
- Full scan, SETTLE=1: mask=16'hFFFF, mux drives in=16'hA5C3.
  - mux_sel steps 0..15, each held for 2 cycles.
  - done occurs 32 cycles after accept; word=16'hA5C3 and valid=1.
- Sparse mask, SETTLE=0: mask=16'h8001, in=16'hFFFF.
  - mux_sel goes 0 then 15.
  - done in the cycle after E0+2; word=16'h8001.
- mask=0: done in the cycle after accept, word=0. start pulses while busy during a later scan are ignored, shown by exactly one done pulse.
- abort mid-scan (SETTLE=3, after 5 channels): returns to IDLE next cycle with no done pulse, and word keeps its previous value. A following start completes normally.
- Async reset asserted mid-SETTLE: outputs clear without waiting for a clock edge, and no done pulse appears after release.
